// File: rtl/execute_writeback_stage23.sv
// -----------------------------------------------------------------------------
// execute_writeback_stage23
//
// Pipeline controller for stage 2 (execute/memory) and stage 3 (writeback) of
// the pipelined BPF CPU.
//
// It registers the pre-decoded control bundle from the stage-1 decoder and
// drives the stage-2 datapath controls. Conditional jumps are resolved from
// the live ALU flags. The A/X write controls are carried on to stage 3.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   stage1_valid/_stalled      stage-1 handshake (real instruction / hazard stall)
//   *_decoded, jmp_type        stage-1 control bundle
//   ALU_eq/gt/ge/set           stage-2 ALU flags used for jump resolution
//   mem_busy                   packet memory not ready; freezes stages 2 and 3
//   ALU_sel .. regfile_wr_en   stage-2 datapath controls
//   PC_sel, PC_en              jump target select / executed jump
//   A_sel, X_sel, A_en, X_en   stage-3 register write controls
//   stage{2,3}_{A,X}_en        hazard feedback to stage 1 (not gated by mem_busy)
//   branch_flush               discard the instructions in stages 0/1
//   stage2_stalled             stages 0/1 must not advance
// -----------------------------------------------------------------------------
module execute_writeback_stage23 #(
  parameter logic [1:0] PC_SEL_JT = 2'd0,
  parameter logic [1:0] PC_SEL_JF = 2'd1,
  parameter logic [1:0] PC_SEL_K  = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stage1_valid,
  input  logic       stage1_stalled,
  input  logic [3:0] ALU_sel_decoded,
  input  logic [2:0] jmp_type,
  input  logic       PC_en_decoded,
  input  logic       packet_mem_rd_en_decoded,
  input  logic       regfile_sel_decoded,
  input  logic       regfile_wr_en_decoded,
  input  logic [1:0] transfer_sz_decoded,
  input  logic [2:0] A_sel_decoded,
  input  logic [2:0] X_sel_decoded,
  input  logic       A_en_decoded,
  input  logic       X_en_decoded,
  input  logic       ALU_eq,
  input  logic       ALU_gt,
  input  logic       ALU_ge,
  input  logic       ALU_set,
  input  logic       mem_busy,
  output logic [3:0] ALU_sel,
  output logic [1:0] PC_sel,
  output logic       PC_en,
  output logic       packet_mem_rd_en,
  output logic [1:0] transfer_sz,
  output logic       regfile_sel,
  output logic       regfile_wr_en,
  output logic [2:0] A_sel,
  output logic [2:0] X_sel,
  output logic       A_en,
  output logic       X_en,
  output logic       stage2_A_en,
  output logic       stage2_X_en,
  output logic       stage3_A_en,
  output logic       stage3_X_en,
  output logic       branch_flush,
  output logic       stage2_stalled
);

  // Stage-2 registers
  logic       s2_valid_q,  s2_valid_d;
  logic [3:0] s2_alu_sel_q, s2_alu_sel_d;
  logic [2:0] s2_jmp_type_q, s2_jmp_type_d;
  logic       s2_pc_en_q, s2_pc_en_d;
  logic       s2_rd_en_q, s2_rd_en_d;
  logic       s2_rf_sel_q, s2_rf_sel_d;
  logic       s2_rf_wr_en_q, s2_rf_wr_en_d;
  logic [1:0] s2_tsz_q, s2_tsz_d;
  logic [2:0] s2_a_sel_q, s2_a_sel_d;
  logic [2:0] s2_x_sel_q, s2_x_sel_d;
  logic       s2_a_en_q, s2_a_en_d;
  logic       s2_x_en_q, s2_x_en_d;

  // Stage-3 registers (only the writeback controls travel this far)
  logic       s3_valid_q, s3_valid_d;
  logic [2:0] s3_a_sel_q, s3_a_sel_d;
  logic [2:0] s3_x_sel_q, s3_x_sel_d;
  logic       s3_a_en_q, s3_a_en_d;
  logic       s3_x_en_q, s3_x_en_d;

  logic       capture;
  logic [1:0] jump_target;

  // A flushing jump in stage 2 turns this cycle's capture into a bubble:
  // the instruction offered by stage 1 was fetched down the wrong path.
  assign capture = stage1_valid & ~stage1_stalled & ~branch_flush;

  always_comb begin
    // Hold by default; mem_busy freezes both stages.
    s2_valid_d    = s2_valid_q;
    s2_alu_sel_d  = s2_alu_sel_q;
    s2_jmp_type_d = s2_jmp_type_q;
    s2_pc_en_d    = s2_pc_en_q;
    s2_rd_en_d    = s2_rd_en_q;
    s2_rf_sel_d   = s2_rf_sel_q;
    s2_rf_wr_en_d = s2_rf_wr_en_q;
    s2_tsz_d      = s2_tsz_q;
    s2_a_sel_d    = s2_a_sel_q;
    s2_x_sel_d    = s2_x_sel_q;
    s2_a_en_d     = s2_a_en_q;
    s2_x_en_d     = s2_x_en_q;
    s3_valid_d    = s3_valid_q;
    s3_a_sel_d    = s3_a_sel_q;
    s3_x_sel_d    = s3_x_sel_q;
    s3_a_en_d     = s3_a_en_q;
    s3_x_en_d     = s3_x_en_q;

    if (!mem_busy) begin
      s3_valid_d = s2_valid_q;
      s3_a_sel_d = s2_a_sel_q;
      s3_x_sel_d = s2_x_sel_q;
      s3_a_en_d  = s2_a_en_q;
      s3_x_en_d  = s2_x_en_q;

      if (capture) begin
        s2_valid_d    = 1'b1;
        s2_alu_sel_d  = ALU_sel_decoded;
        s2_jmp_type_d = jmp_type;
        s2_pc_en_d    = PC_en_decoded;
        s2_rd_en_d    = packet_mem_rd_en_decoded;
        s2_rf_sel_d   = regfile_sel_decoded;
        s2_rf_wr_en_d = regfile_wr_en_decoded;
        s2_tsz_d      = transfer_sz_decoded;
        s2_a_sel_d    = A_sel_decoded;
        s2_x_sel_d    = X_sel_decoded;
        s2_a_en_d     = A_en_decoded;
        s2_x_en_d     = X_en_decoded;
      end else begin
        // Bubble: clear every field so no stale control leaks downstream.
        s2_valid_d    = 1'b0;
        s2_alu_sel_d  = '0;
        s2_jmp_type_d = '0;
        s2_pc_en_d    = 1'b0;
        s2_rd_en_d    = 1'b0;
        s2_rf_sel_d   = 1'b0;
        s2_rf_wr_en_d = 1'b0;
        s2_tsz_d      = '0;
        s2_a_sel_d    = '0;
        s2_x_sel_d    = '0;
        s2_a_en_d     = 1'b0;
        s2_x_en_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid_q    <= 1'b0;
      s2_alu_sel_q  <= '0;
      s2_jmp_type_q <= '0;
      s2_pc_en_q    <= 1'b0;
      s2_rd_en_q    <= 1'b0;
      s2_rf_sel_q   <= 1'b0;
      s2_rf_wr_en_q <= 1'b0;
      s2_tsz_q      <= '0;
      s2_a_sel_q    <= '0;
      s2_x_sel_q    <= '0;
      s2_a_en_q     <= 1'b0;
      s2_x_en_q     <= 1'b0;
      s3_valid_q    <= 1'b0;
      s3_a_sel_q    <= '0;
      s3_x_sel_q    <= '0;
      s3_a_en_q     <= 1'b0;
      s3_x_en_q     <= 1'b0;
    end else begin
      s2_valid_q    <= s2_valid_d;
      s2_alu_sel_q  <= s2_alu_sel_d;
      s2_jmp_type_q <= s2_jmp_type_d;
      s2_pc_en_q    <= s2_pc_en_d;
      s2_rd_en_q    <= s2_rd_en_d;
      s2_rf_sel_q   <= s2_rf_sel_d;
      s2_rf_wr_en_q <= s2_rf_wr_en_d;
      s2_tsz_q      <= s2_tsz_d;
      s2_a_sel_q    <= s2_a_sel_d;
      s2_x_sel_q    <= s2_x_sel_d;
      s2_a_en_q     <= s2_a_en_d;
      s2_x_en_q     <= s2_x_en_d;
      s3_valid_q    <= s3_valid_d;
      s3_a_sel_q    <= s3_a_sel_d;
      s3_x_sel_q    <= s3_x_sel_d;
      s3_a_en_q     <= s3_a_en_d;
      s3_x_en_q     <= s3_x_en_d;
    end
  end

  // Jump resolution on the registered jump type and the live ALU flags.
  always_comb begin
    jump_target = PC_SEL_JF;
    case (s2_jmp_type_q)
      3'd0:    jump_target = PC_SEL_K;
      3'd1:    jump_target = ALU_eq  ? PC_SEL_JT : PC_SEL_JF;
      3'd2:    jump_target = ALU_gt  ? PC_SEL_JT : PC_SEL_JF;
      3'd3:    jump_target = ALU_ge  ? PC_SEL_JT : PC_SEL_JF;
      3'd4:    jump_target = ALU_set ? PC_SEL_JT : PC_SEL_JF;
      default: jump_target = PC_SEL_JF;
    endcase
  end

  // Side-effecting controls are suppressed while frozen so they fire once.
  assign PC_en            = s2_valid_q & s2_pc_en_q & ~mem_busy;
  assign PC_sel           = PC_en ? jump_target : 2'd0;
  assign branch_flush     = PC_en;
  assign regfile_wr_en    = s2_valid_q & s2_rf_wr_en_q & ~mem_busy;
  assign ALU_sel          = s2_valid_q ? s2_alu_sel_q : 4'd0;
  assign transfer_sz      = s2_valid_q ? s2_tsz_q : 2'd0;
  assign regfile_sel      = s2_valid_q & s2_rf_sel_q;
  // The read request stays up through a freeze so memory keeps serving it.
  assign packet_mem_rd_en = s2_valid_q & s2_rd_en_q;
  assign stage2_stalled   = mem_busy;

  assign A_en  = s3_valid_q & s3_a_en_q & ~mem_busy;
  assign X_en  = s3_valid_q & s3_x_en_q & ~mem_busy;
  assign A_sel = s3_valid_q ? s3_a_sel_q : 3'd0;
  assign X_sel = s3_valid_q ? s3_x_sel_q : 3'd0;

  assign stage2_A_en = s2_valid_q & s2_a_en_q;
  assign stage2_X_en = s2_valid_q & s2_x_en_q;
  assign stage3_A_en = s3_valid_q & s3_a_en_q;
  assign stage3_X_en = s3_valid_q & s3_x_en_q;

endmodule

// File: tb/tb_execute_writeback_stage23.sv
// -----------------------------------------------------------------------------
// tb_execute_writeback_stage23
//
// Scoreboard bench: the stimulus process computes the expected outputs of each
// cycle from an instruction-level pipeline model and queues them; a monitor
// compares the DUT outputs on every falling edge. Directed scenarios come
// first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_execute_writeback_stage23;

  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] jt;
    logic       pc_en;
    logic       rd;
    logic [1:0] tsz;
    logic       rs;
    logic       rwe;
    logic [2:0] asel;
    logic [2:0] xsel;
    logic       aen;
    logic       xen;
  } instr_t;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       rd_en;
    logic [1:0] tsz;
    logic       rf_sel;
    logic       rf_wr_en;
    logic [2:0] a_sel;
    logic [2:0] x_sel;
    logic       a_en;
    logic       x_en;
    logic       s2a;
    logic       s2x;
    logic       s3a;
    logic       s3x;
    logic       flush;
    logic       stalled;
  } outv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s1_valid, s1_stalled, mem_busy;
  logic       f_eq, f_gt, f_ge, f_set;
  instr_t     din;

  logic [3:0] ALU_sel;
  logic [1:0] PC_sel;
  logic       PC_en, packet_mem_rd_en, regfile_sel, regfile_wr_en;
  logic [1:0] transfer_sz;
  logic [2:0] A_sel, X_sel;
  logic       A_en, X_en;
  logic       stage2_A_en, stage2_X_en, stage3_A_en, stage3_X_en;
  logic       branch_flush, stage2_stalled;

  execute_writeback_stage23 dut (
    .clk                      (clk),
    .rst                      (rst),
    .stage1_valid             (s1_valid),
    .stage1_stalled           (s1_stalled),
    .ALU_sel_decoded          (din.alu),
    .jmp_type                 (din.jt),
    .PC_en_decoded            (din.pc_en),
    .packet_mem_rd_en_decoded (din.rd),
    .regfile_sel_decoded      (din.rs),
    .regfile_wr_en_decoded    (din.rwe),
    .transfer_sz_decoded      (din.tsz),
    .A_sel_decoded            (din.asel),
    .X_sel_decoded            (din.xsel),
    .A_en_decoded             (din.aen),
    .X_en_decoded             (din.xen),
    .ALU_eq                   (f_eq),
    .ALU_gt                   (f_gt),
    .ALU_ge                   (f_ge),
    .ALU_set                  (f_set),
    .mem_busy                 (mem_busy),
    .ALU_sel                  (ALU_sel),
    .PC_sel                   (PC_sel),
    .PC_en                    (PC_en),
    .packet_mem_rd_en         (packet_mem_rd_en),
    .transfer_sz              (transfer_sz),
    .regfile_sel              (regfile_sel),
    .regfile_wr_en            (regfile_wr_en),
    .A_sel                    (A_sel),
    .X_sel                    (X_sel),
    .A_en                     (A_en),
    .X_en                     (X_en),
    .stage2_A_en              (stage2_A_en),
    .stage2_X_en              (stage2_X_en),
    .stage3_A_en              (stage3_A_en),
    .stage3_X_en              (stage3_X_en),
    .branch_flush             (branch_flush),
    .stage2_stalled           (stage2_stalled)
  );

  outv_t got;
  assign got = '{alu_sel: ALU_sel, pc_sel: PC_sel, pc_en: PC_en,
                 rd_en: packet_mem_rd_en, tsz: transfer_sz, rf_sel: regfile_sel,
                 rf_wr_en: regfile_wr_en, a_sel: A_sel, x_sel: X_sel,
                 a_en: A_en, x_en: X_en, s2a: stage2_A_en, s2x: stage2_X_en,
                 s3a: stage3_A_en, s3x: stage3_X_en, flush: branch_flush,
                 stalled: stage2_stalled};

  // Reference model: which instruction (if any) sits in stages 2 and 3.
  instr_t m2, m3;
  bit     v2, v3;
  outv_t  exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_txn    = 0;

  function automatic outv_t model_out();
    outv_t e;
    bit    taken;
    e = '0;
    e.stalled = mem_busy;
    if (v2) begin
      e.alu_sel  = m2.alu;
      e.tsz      = m2.tsz;
      e.rf_sel   = m2.rs;
      e.rd_en    = m2.rd;
      e.s2a      = m2.aen;
      e.s2x      = m2.xen;
      e.rf_wr_en = m2.rwe && !mem_busy;
      e.pc_en    = m2.pc_en && !mem_busy;
    end
    if (e.pc_en) begin
      if (m2.jt == 3'd0) e.pc_sel = 2'd2;
      else begin
        case (m2.jt)
          3'd1:    taken = f_eq;
          3'd2:    taken = f_gt;
          3'd3:    taken = f_ge;
          3'd4:    taken = f_set;
          default: taken = 1'b0;
        endcase
        e.pc_sel = taken ? 2'd0 : 2'd1;
      end
    end
    e.flush = e.pc_en;
    if (v3) begin
      e.a_sel = m3.asel;
      e.x_sel = m3.xsel;
      e.s3a   = m3.aen;
      e.s3x   = m3.xen;
      e.a_en  = m3.aen && !mem_busy;
      e.x_en  = m3.xen && !mem_busy;
    end
    return e;
  endfunction

  // One clock cycle: queue this cycle's expected outputs, then advance model.
  task automatic step();
    outv_t e;
    e = model_out();
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      v2 = 0; m2 = '0; v3 = 0; m3 = '0;
    end else if (!mem_busy) begin
      v3 = v2; m3 = m2;
      if (s1_valid && !s1_stalled && !e.flush) begin v2 = 1; m2 = din; end
      else begin v2 = 0; m2 = '0; end
    end
    #1;
  endtask

  task automatic issue(input instr_t i);
    din = i; s1_valid = 1'b1; step();
  endtask

  task automatic idle(input int n);
    s1_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic instr_t mk(input logic [3:0] alu, input logic [2:0] jt,
                                input logic pc_en, input logic rd,
                                input logic [2:0] asel, input logic aen,
                                input logic rwe);
    instr_t i;
    i = '0;
    i.alu = alu; i.jt = jt; i.pc_en = pc_en; i.rd = rd;
    i.asel = asel; i.aen = aen; i.rwe = rwe;
    return i;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outv_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_txn++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs txn %0d: got=%07h required=%07h", n_txn, got, e);
      end else begin
        $display("txn %0d ok outputs=%07h", n_txn, got);
      end
    end
  end

  initial begin
    rst = 1'b0; s1_valid = 0; s1_stalled = 0; mem_busy = 0;
    f_eq = 0; f_gt = 0; f_ge = 0; f_set = 0; din = '0;
    v2 = 0; v3 = 0; m2 = '0; m3 = '0;
    @(posedge clk); #1;
    step();                       // outputs must be zero after reset
    rst = 1'b1;

    // ALU ADD through stages 2 and 3
    issue(mk(4'd0, 3'd0, 0, 0, 3'd2, 1, 0));
    idle(3);

    // JEQ taken, JEQ not taken, jmp_type 6; stage 1 keeps offering a bubble victim
    f_eq = 1;
    issue(mk(4'd1, 3'd1, 1, 0, 3'd0, 0, 0));
    issue(mk(4'd0, 3'd0, 0, 0, 3'd2, 1, 1));
    idle(2);
    f_eq = 0;
    issue(mk(4'd1, 3'd1, 1, 0, 3'd0, 0, 0));
    issue(mk(4'd0, 3'd0, 0, 0, 3'd2, 1, 1));
    idle(2);
    f_eq = 1; f_gt = 1; f_ge = 1; f_set = 1;
    issue(mk(4'd1, 3'd6, 1, 0, 3'd0, 0, 0));
    idle(2);
    // JA
    issue(mk(4'd0, 3'd0, 1, 0, 3'd0, 0, 0));
    idle(3);

    // Hazard stall from stage 1
    s1_stalled = 1;
    issue(mk(4'd2, 3'd0, 0, 0, 3'd2, 1, 1));
    s1_stalled = 0;
    idle(2);

    // LD ABS frozen by mem_busy for three cycles
    issue(mk(4'd0, 3'd0, 0, 1, 3'd1, 1, 0));
    mem_busy = 1;
    issue(mk(4'd3, 3'd0, 0, 0, 3'd2, 1, 1));
    step(); step();
    mem_busy = 0;
    idle(3);

    // Reset with a jump in stage 2 and an ALU op in stage 3
    issue(mk(4'd0, 3'd0, 0, 0, 3'd2, 1, 0));
    issue(mk(4'd1, 3'd0, 1, 0, 3'd0, 0, 0));
    rst = 0; s1_valid = 0; step();
    rst = 1; idle(4);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst        = ($urandom_range(0, 99) >= 3);
      mem_busy   = ($urandom_range(0, 99) < 25);
      s1_valid   = ($urandom_range(0, 99) < 70);
      s1_stalled = ($urandom_range(0, 99) < 15);
      {f_eq, f_gt, f_ge, f_set} = 4'($urandom);
      din = instr_t'($urandom);
      step();
    end
    rst = 1; mem_busy = 0; s1_valid = 0;
    idle(2);

    // Let the monitor drain; leftovers count as a failure.
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_writeback_stage23.md
Name: execute_writeback_stage23

Overview:
- Pipeline controller for stages 2 (execute/memory) and 3 (writeback) of the pipelined BPF CPU.
- Registers the pre-decoded control bundle produced by the stage-1 decoder and drives the stage-2 datapath controls.
- Resolves conditional jumps from the ALU flags and forwards the A/X write controls to stage 3.
- Returns the stage2/stage3 A_en/X_en hazard signals to stage 1, and issues a flush on executed jumps and a freeze when packet memory is busy.

Parameters:
- PC_SEL_JT, 2'd0, PC_sel code: PC += jt + 1.
- PC_SEL_JF, 2'd1, PC_sel code: PC += jf + 1.
- PC_SEL_K, 2'd2, PC_sel code: PC += k + 1 (JA).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- stage1_valid  input  1  stage 1 holds a real instruction.
- stage1_stalled  input  1  stage-1 hazard stall; stage 2 receives a bubble.
- ALU_sel_decoded  input  4  from stage 1.
- jmp_type  input  3  from stage 1; JA=0, JEQ=1, JGT=2, JGE=3, JSET=4.
- PC_en_decoded, packet_mem_rd_en_decoded, regfile_sel_decoded, regfile_wr_en_decoded  input  1 each  from stage 1.
- transfer_sz_decoded  input  2  from stage 1.
- A_sel_decoded, X_sel_decoded  input  3 each  from stage 1.
- A_en_decoded, X_en_decoded  input  1 each  from stage 1.
- ALU_eq, ALU_gt, ALU_ge, ALU_set  input  1 each  stage-2 ALU flags (A vs B; set = (A&B)!=0).
- mem_busy  input  1  packet memory not ready; freezes stages 2 and 3.
- ALU_sel  output  4  stage-2 ALU op.
- PC_sel  output  2  jump target select.
- PC_en  output  1  executed jump.
- packet_mem_rd_en  output  1  stage-2 packet read.
- transfer_sz  output  2  stage-2 transfer size.
- regfile_sel  output  1  stage-2 scratch write source.
- regfile_wr_en  output  1  stage-2 scratch write enable.
- A_sel, X_sel  output  3 each  stage-3 register input selects.
- A_en, X_en  output  1 each  stage-3 register writes.
- stage2_A_en, stage2_X_en, stage3_A_en, stage3_X_en  output  1 each  hazard feedback to stage 1.
- branch_flush  output  1  discard the instruction in stages 0/1.
- stage2_stalled  output  1  stages 0/1 must not advance.

Behaviour:
- Reset (rst=0 at an edge):
  - s2_valid=0, s3_valid=0.
  - All registered fields cleared.
  - Every output is 0 in the following cycle.
  - Reset overrides mem_busy and mid-flight instructions; no pending side effect survives.
- Stage-2 capture, when mem_busy=0:
  - If stage1_valid=1, stage1_stalled=0 and branch_flush=0: s2 fields <= decoded inputs, s2_valid <= 1.
  - Otherwise: s2_valid <= 0 and all s2 fields <= 0 (bubble).
  - Latency: a decoded bundle drives stage-2 outputs exactly 1 cycle after capture.
- Stage-3 capture, when mem_busy=0: s3 A/X fields <= s2 A/X fields, s3_valid <= s2_valid.
  - Latency: stage-1 decode to A_en/X_en is 2 cycles.
- Freeze (mem_busy=1):
  - s2 and s3 registers hold.
  - stage2_stalled=1 (combinational from mem_busy).
  - PC_en, regfile_wr_en, A_en, X_en, branch_flush forced 0, so no side effect fires twice.
  - packet_mem_rd_en stays at its s2 value so the read remains requested.
  - Hazard feedback outputs keep reflecting the held contents.
- Stage-2 outputs:
  - ALU_sel, transfer_sz, regfile_sel, packet_mem_rd_en come from the s2 fields, gated by s2_valid.
  - regfile_wr_en = s2_valid & s2.regfile_wr_en & !mem_busy.
  - PC_en = s2_valid & s2.PC_en & !mem_busy.
- Jump resolution (combinational on the registered jmp_type and live flags):
  - JA -> PC_SEL_K.
  - JEQ/JGT/JGE/JSET -> PC_SEL_JT if ALU_eq/gt/ge/set respectively, else PC_SEL_JF.
  - jmp_type 5..7 -> PC_SEL_JF (not taken).
  - PC_sel = 0 when PC_en=0.
- branch_flush = PC_en.
  - Every executed jump flushes, including not-taken ones.
  - The same cycle's stage-2 capture is a bubble.
- Stage-3 outputs:
  - A_en = s3_valid & s3.A_en & !mem_busy; X_en likewise.
  - A_sel/X_sel = s3 fields when s3_valid, else 0.
- Hazard feedback:
  - stage2_A_en = s2_valid & s2.A_en; stage2_X_en likewise.
  - stage3_A_en = s3_valid & s3.A_en; stage3_X_en likewise.
  - These are not gated by mem_busy.
- Simultaneous events:
  - mem_busy has priority over flush and capture.
  - Reset has priority over everything.

Test Plan:
- ALU ADD (ALU_sel=0, A_en=1, A_sel=A_SEL_ALU) with stage1_valid=1 at cycle 0 -> ALU_sel=0 and stage2_A_en=1 at cycle 1; A_en=1, A_sel=A_SEL_ALU, stage3_A_en=1 at cycle 2; all 0 at cycle 3.
- JEQ with ALU_eq=1 -> cycle 1: PC_en=1, PC_sel=0, branch_flush=1; the next cycle's stage 2 is a bubble even though stage1_valid=1. Repeat with ALU_eq=0 -> PC_sel=1. Repeat with jmp_type=6 -> PC_sel=1.
- JA (jmp_type=0) -> PC_sel=2, PC_en=1 for exactly one cycle.
- stage1_stalled=1 with stage1_valid=1 -> stage-2 bubble: stage2_A_en=0, regfile_wr_en=0 the next cycle.
- LD ABS (packet_mem_rd_en=1, A_en=1) in stage 2, then mem_busy=1 for 3 cycles -> packet_mem_rd_en held at 1, stage2_stalled=1, stage2_A_en=1, A_en=0 throughout. After release, A_en=1 for exactly one cycle.
- rst=0 asserted while a jump is in stage 2 and an ALU op is in stage 3 -> next cycle all outputs 0. After rst=1, no A_en or PC_en pulse occurs until a new instruction is issued.
